// File: rtl/serial_subtractor_unit.sv
// Digit-serial A - B - borrowIn unit: one DIGIT-bit ripple-borrow slice reused over WIDTH/DIGIT cycles.
// Supports SUB, ABS (second serial negate pass) and CMP, with valid/ready handshakes on both sides.
`timescale 1ns/1ps
module serial_subtractor_unit #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowIn,
  input  logic [1:0]       mode,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEG, S_DONE} state_t;
  typedef enum logic [1:0] {M_SUB = 2'b00, M_ABS = 2'b01, M_CMP = 2'b10, M_RSV = 2'b11} mode_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_armed;
  mode_t            r_mode;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic             r_ovfSign;
  logic             r_aMsb;
  logic             r_runBorrow;
  logic             r_runZero;
  logic             r_runOvf;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrowOut;
  logic             r_zero;
  logic             r_overflow;

  logic             w_accept;
  logic             w_lastStep;
  logic [DIGIT-1:0] w_sliceD;
  logic             w_sliceB;
  logic [WIDTH-1:0] w_resNext;
  logic             w_fZero;
  logic             w_fOvf;
  logic             w_goNeg;

  assign w_accept   = inValid & inReady;
  assign w_lastStep = (r_cnt == CW'(N - 1));

  // Shared DIGIT-bit ripple-borrow slice
  always_comb begin
    logic bb;
    logic x;
    logic y;
    bb       = r_brw;
    w_sliceD = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      x           = r_opA[i];
      y           = r_opB[i];
      w_sliceD[i] = x ^ y ^ bb;
      bb          = (~x & y) | (~(x ^ y) & bb);
    end
    w_sliceB = bb;
  end

  generate
    if (DIGIT == WIDTH) begin : g_full
      assign w_resNext = w_sliceD;
    end else begin : g_serial
      assign w_resNext = {w_sliceD, r_res[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_fZero = (w_resNext == '0);
  assign w_fOvf  = r_ovfSign & (w_resNext[WIDTH-1] != r_aMsb);
  assign w_goNeg = (r_mode == M_ABS) & w_sliceB;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_lastStep) w_next = w_goNeg ? S_NEG : S_DONE;
      S_NEG:   if (w_lastStep) w_next = S_DONE;
      S_DONE:  if (outReady) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    inReady  = (r_state == S_IDLE) & r_armed;
    outValid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_armed     <= 1'b0;
      r_mode      <= M_SUB;
      r_opA       <= '0;
      r_opB       <= '0;
      r_res       <= '0;
      r_brw       <= 1'b0;
      r_cnt       <= '0;
      r_ovfSign   <= 1'b0;
      r_aMsb      <= 1'b0;
      r_runBorrow <= 1'b0;
      r_runZero   <= 1'b0;
      r_runOvf    <= 1'b0;
      r_diff      <= '0;
      r_borrowOut <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opA     <= a;
            r_opB     <= b;
            r_mode    <= mode_t'(mode);
            r_brw     <= borrowIn;
            r_cnt     <= '0;
            r_ovfSign <= a[WIDTH-1] != b[WIDTH-1];
            r_aMsb    <= a[WIDTH-1];
          end
        end
        S_RUN: begin
          r_opA <= r_opA >> DIGIT;
          r_opB <= r_opB >> DIGIT;
          r_res <= w_resNext;
          r_brw <= w_sliceB;
          r_cnt <= w_lastStep ? '0 : r_cnt + CW'(1);
          if (w_lastStep) begin
            // RUN-pass flags are kept aside so the ABS negate pass cannot disturb them
            r_runBorrow <= w_sliceB;
            r_runZero   <= w_fZero;
            r_runOvf    <= w_fOvf;
            if (w_goNeg) begin
              r_opA <= '0;
              r_opB <= w_resNext;
              r_brw <= 1'b0;
            end else begin
              r_diff      <= (r_mode == M_CMP) ? '0 : w_resNext;
              r_borrowOut <= w_sliceB;
              r_zero      <= w_fZero;
              r_overflow  <= w_fOvf;
            end
          end
        end
        S_NEG: begin
          r_opA <= r_opA >> DIGIT;
          r_opB <= r_opB >> DIGIT;
          r_res <= w_resNext;
          r_brw <= w_sliceB;
          r_cnt <= w_lastStep ? '0 : r_cnt + CW'(1);
          if (w_lastStep) begin
            r_diff      <= w_resNext;
            r_borrowOut <= r_runBorrow;
            r_zero      <= r_runZero;
            r_overflow  <= r_runOvf;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff      = r_diff;
  assign borrowOut = r_borrowOut;
  assign zero      = r_zero;
  assign overflow  = r_overflow;

endmodule
